// File: rtl/ram_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_stream_reader_pkg
// Description : Shared constants for the RAM stream reader: FSM state
//               encoding and stream beat layout (data + last flag).
// Revision    : 1.0 - initial release
// ============================================================================
package ram_stream_reader_pkg;

  // FSM state encoding
  localparam int         c_STATE_W  = 2;
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_READ  = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;

  // A stream beat is {last, data}; the last flag sits above the data bits
  localparam int c_LAST_W = 1;

  function automatic int beat_width(input int data_w);
    return data_w + c_LAST_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : stream_fifo2
// Description : Two-entry synchronous FIFO with first-word fall-through head
//               output. Simultaneous push/pop is accepted when full (the pop
//               frees the slot) and a pop on empty is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo2 #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Qualify push/pop against occupancy
  always_comb begin
    w_do_pop  = pop & (r_count != 2'd0);
    w_do_push = push & ((r_count != 2'd2) | w_do_pop);
  end

  // Storage, pointers and occupancy; storage clears so the head reads 0 after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == 2'd2);
  assign empty = (r_count == 2'd0);
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : ram_stream_reader
// Description : Fetches a contiguous (wrapping) block of words from a
//               single-port synchronous RAM and streams them out on a
//               valid/ready interface, one word per clock when unstalled.
//               Reads are only issued when the 2-entry buffer is guaranteed
//               to have room for the returning word.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int addr_width = 3,
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [addr_width-1:0] base_addr,
  input  logic [addr_width:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] ram_addr,
  output logic                  ram_we,
  output logic [data_width-1:0] ram_din,
  input  logic [data_width-1:0] ram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [data_width-1:0] m_data,
  output logic                  m_last
);

  localparam int c_BEAT_W = beat_width(data_width);
  localparam logic [addr_width:0]   c_CNT_ONE  = (addr_width+1)'(1);
  localparam logic [addr_width-1:0] c_ADDR_ONE = addr_width'(1);

  logic [c_STATE_W-1:0]  r_state;
  logic [c_STATE_W-1:0]  w_next_state;
  logic [addr_width-1:0] r_addr;
  logic [addr_width:0]   r_issue_cnt;
  logic [addr_width:0]   r_beat_cnt;
  logic                  r_pend;
  logic                  r_pend_last;
  logic                  r_done;

  logic                  w_cmd_go;
  logic                  w_cmd_zero;
  logic                  w_issue;
  logic                  w_pop;
  logic                  w_last_pop;
  logic                  w_credit;
  logic [2:0]            w_occ;
  logic                  w_full;
  logic                  w_empty;
  logic [1:0]            w_count;
  logic [c_BEAT_W-1:0]   w_head;

  // Occupancy after this cycle's pop, counting the word already in flight from RAM
  always_comb begin
    w_pop    = ~w_empty & m_ready;
    w_occ    = {1'b0, w_count} + {2'b00, r_pend} - {2'b00, w_pop};
    w_credit = w_full ? (w_pop & ~r_pend) : (w_occ < 3'd2);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_cmd_go) w_next_state = c_ST_READ;
      c_ST_READ:  if (w_issue && (r_issue_cnt == c_CNT_ONE)) w_next_state = c_ST_DRAIN;
      c_ST_DRAIN: if (w_last_pop) w_next_state = c_ST_IDLE;
      default:    w_next_state = c_ST_IDLE;
    endcase
  end

  // FSM-decoded controls
  always_comb begin
    w_cmd_go   = (r_state == c_ST_IDLE) & start & (length != '0);
    w_cmd_zero = (r_state == c_ST_IDLE) & start & (length == '0);
    w_issue    = (r_state == c_ST_READ) & w_credit;
    w_last_pop = (r_state == c_ST_DRAIN) & w_pop & (r_beat_cnt == c_CNT_ONE);
    busy       = (r_state != c_ST_IDLE);
  end

  // Address/count bookkeeping, in-flight read tracking and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_issue_cnt <= '0;
      r_beat_cnt  <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_cmd_go) begin
        r_addr      <= base_addr;
        r_issue_cnt <= length;
        r_beat_cnt  <= length;
      end else begin
        if (w_issue) begin
          r_addr      <= r_addr + c_ADDR_ONE;
          r_issue_cnt <= r_issue_cnt - c_CNT_ONE;
        end
        if (w_pop) begin
          r_beat_cnt <= r_beat_cnt - c_CNT_ONE;
        end
      end
      r_pend      <= w_issue;
      r_pend_last <= w_issue & (r_issue_cnt == c_CNT_ONE);
      r_done      <= w_cmd_zero | w_last_pop;
    end
  end

  stream_fifo2 #(
    .WIDTH(c_BEAT_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (r_pend),
    .din  ({r_pend_last, ram_dout}),
    .pop  (w_pop),
    .dout (w_head),
    .full (w_full),
    .empty(w_empty),
    .count(w_count)
  );

  assign done     = r_done;
  assign ram_addr = r_addr;
  assign ram_we   = 1'b0;
  assign ram_din  = '0;
  assign m_valid  = ~w_empty;
  assign m_data   = w_head[data_width-1:0];
  assign m_last   = w_head[data_width];

endmodule
`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_stream_reader
// Description : Self-checking bench for ram_stream_reader. A behavioural RAM
//               feeds the DUT; expected beats are computed directly from the
//               memory image as mem[(base+k) mod depth].
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_stream_reader;

  localparam int AW    = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  logic [DW-1:0] mem [DEPTH];
  int vectors    = 0;
  int miscompares = 0;
  int pat [7] = '{1, 0, 0, 1, 0, 1, 1};

  ram_stream_reader #(.addr_width(AW), .data_width(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: 1-cycle registered read
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic fill_ramp();
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h100 + i;
  endtask

  // Drives one command and checks the resulting beats, stalls and done pulse.
  // mode: 0 = ready always high, 1 = fixed 1,0,0,1,0,1,1 pattern, 2 = random
  task automatic run_transfer(input int base, input int len, input int mode,
                              input bit inject, input bit chk_latency);
    logic [DW-1:0] exp_q [$];
    int k, cyc, first_valid, last_hs, issued;
    bit prev_stall, rdy, ended;
    logic [DW-1:0] prev_data;
    logic prev_last;
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(base + i) % DEPTH]);
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(base); length = (AW+1)'(len);
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
    k = 0; cyc = 0; first_valid = -1; last_hs = -1;
    prev_stall = 1'b0; ended = 1'b0; prev_data = '0; prev_last = 1'b0;
    while (!ended && cyc < len * 10 + 20) begin
      if (inject && cyc == 1) begin
        start = 1'b1; base_addr = AW'(4); length = (AW+1)'(3);
      end else begin
        start = 1'b0;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (pat[cyc % 7] != 0);
        default: rdy = (($urandom % 4) != 0);
      endcase
      m_ready = rdy;
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("FAIL early_done: cyc %0d got %b want 0", cyc, done);
      end
      if (len < DEPTH) begin
        issued = (int'(ram_addr) - base + DEPTH) % DEPTH;
        vectors++;
        if (issued - k > 2) begin
          miscompares++;
          $display("FAIL credit: issued %0d consumed %0d, want at most 2 ahead", issued, k);
        end
      end
      if (prev_stall) begin
        vectors++;
        if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
          miscompares++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   m_valid, m_data, m_last, prev_data, prev_last);
        end
      end
      if (m_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (m_valid === 1'b1 && rdy) begin
        vectors++;
        if (k >= len) begin
          miscompares++;
          $display("FAIL extra_beat: got %h want no beat", m_data);
        end else if (m_data !== exp_q[k] || m_last !== (k == len - 1)) begin
          miscompares++;
          $display("FAIL beat%0d: got d=%h l=%b want d=%h l=%b",
                   k, m_data, m_last, exp_q[k], (k == len - 1));
        end
        k++;
        last_hs = cyc;
      end
      prev_stall = (m_valid === 1'b1) && !rdy;
      prev_data  = m_data;
      prev_last  = m_last;
      @(posedge clk); #1;
      cyc++;
      if (k >= len) begin
        ended = 1'b1;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL done_pulse: got done=%b busy=%b valid=%b want 1 0 0",
                   done, busy, m_valid);
        end
      end
    end
    start = 1'b0;
    if (!ended) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: got %0d beats want %0d", k, len);
    end else begin
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL post_done: got done=%b busy=%b valid=%b want 0 0 0",
                 done, busy, m_valid);
      end
    end
    if (chk_latency) begin
      vectors++;
      if (first_valid != 2 || last_hs != len + 1) begin
        miscompares++;
        $display("FAIL latency: got first=%0d last=%0d want 2 and %0d",
                 first_valid, last_hs, len + 1);
      end
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || ram_addr !== '0 || m_valid !== 1'b0 ||
        m_data !== '0 || m_last !== 1'b0 || ram_we !== 1'b0 || ram_din !== '0) begin
      miscompares++;
      $display("FAIL reset: got busy=%b done=%b addr=%h v=%b d=%h l=%b want all 0",
               busy, done, ram_addr, m_valid, m_data, m_last);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    fill_ramp();
    run_transfer(2, 4, 0, 1'b0, 1'b1);
  endtask

  task automatic test_wrap();
    fill_ramp();
    run_transfer(6, 4, 0, 1'b0, 1'b1);
    run_transfer(5, 8, 0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    fill_ramp();
    run_transfer(0, 6, 1, 1'b0, 1'b0);
  endtask

  task automatic test_zero_length();
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(3); length = '0; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_len_done: got done=%b busy=%b valid=%b want 1 0 0", done, busy, m_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_len_after: got done=%b busy=%b valid=%b want 0 0 0", done, busy, m_valid);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_start_while_busy();
    fill_ramp();
    run_transfer(1, 3, 0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_midop();
    int k;
    int cyc;
    fill_ramp();
    @(posedge clk); #1;
    start = 1'b1; base_addr = '0; length = (AW+1)'(5); m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; cyc = 0;
    while (k < 2 && cyc < 20) begin
      if (m_valid === 1'b1) k++;
      @(posedge clk); #1;
      cyc++;
    end
    vectors++;
    if (k < 2) begin
      miscompares++;
      $display("FAIL midop_beats: got %0d want 2", k);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || ram_addr !== '0 || m_valid !== 1'b0 ||
        m_data !== '0 || m_last !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_reset: got busy=%b done=%b addr=%h v=%b d=%h l=%b want all 0",
               busy, done, ram_addr, m_valid, m_data, m_last);
    end
    repeat (3) begin
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || m_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL midop_quiet: got done=%b valid=%b want 0 0", done, m_valid);
      end
    end
    run_transfer(0, 2, 0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      run_transfer($urandom_range(0, DEPTH - 1), $urandom_range(1, DEPTH), 2, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_start_while_busy();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
